rr_arb_mux: RTL and testbench

- Parametrised, registered N-to-1 multiplexer with a built-in arbiter and valid/ready handshakes on every channel.
- Merges several producer lanes onto one shared consumer port, for example two ALU lanes into a shared CDB or writeback port in the superscalar core.
- Replaces the fixed-width 2/3/5-input combinational selects wherever the select must be arbitrated and the result pipelined.
- Supports round-robin or fixed-priority arbitration, a flush input, and a one-entry output register.

---
 rtl/rr_arb_mux.sv | 126 ++++++++++++
 tb/tb_rr_arb_mux.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Purpose  : Registered N-to-1 multiplexer with a built-in arbiter and
//            valid/ready handshakes on every input channel and on the output.
//            It supports round-robin (PRIO_MODE=0) or fixed lowest-index
//            priority (PRIO_MODE=1) arbitration, a synchronous flush, and a
//            one-entry output register.
// Ports    :
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   flush      in   synchronous flush, active high
//   in_data    in   NUM_IN*WIDTH packed data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NUM_IN per-channel request
//   in_ready   out  NUM_IN per-channel accept (at most one bit high)
//   out_data   out  WIDTH registered selected data
//   out_src    out  SEL_W index of the channel that produced out_data
//   out_valid  out  output register holds a valid item
//   out_ready  in   consumer accepts the output this cycle
// Revision : 1.0  initial release
// ============================================================================
module rr_arb_mux #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int PRIO_MODE = 0,
  localparam int SEL_W    = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;

  logic              w_can_load;
  logic              w_any;
  logic [SEL_W-1:0]  w_sel;
  logic [NUM_IN-1:0] w_grant;
  logic              w_xfer;

  // The output slot can take a new item when it is empty or being drained
  // in the same cycle; a flush blocks all loading.
  assign w_can_load = !flush && (!out_valid_q || out_ready);

  // Request scan. Offsets are visited from the far end towards the base so
  // that the closest requester to the base index is the one left in w_sel.
  // Only in_valid and the pointer feed this path, never in_data.
  always_comb begin
    int base;
    int idx;
    w_any = 1'b0;
    w_sel = '0;
    base  = (PRIO_MODE != 0) ? 0 : int'(ptr_q);
    idx   = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = base + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end
      if (in_valid[idx]) begin
        w_any = 1'b1;
        w_sel = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_any) begin
      w_grant[w_sel] = 1'b1;
    end
  end

  // Gating with rst keeps every in_ready low while reset is held, even
  // though the registers themselves are already cleared.
  assign in_ready = w_grant & {NUM_IN{w_can_load & rst}};
  assign w_xfer   = w_any && w_can_load;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[w_sel*WIDTH +: WIDTH];
      out_src_d   = w_sel;
      ptr_d       = (w_sel == SEL_W'(NUM_IN - 1)) ? '0 : w_sel + 1'b1;
    end else if (out_ready) begin
      // Drain without refill: data and source keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux
// Purpose  : Directed self-checking bench for rr_arb_mux. A round-robin
//            instance (dut0) and a fixed-priority instance (dut1) share the
//            same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic          out_ready;

  logic [N-1:0]  rdy0, rdy1;
  logic [W-1:0]  data0, data1;
  logic [1:0]    src0, src1;
  logic          val0, val1;

  logic [W-1:0]  chdat [N];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N), .PRIO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy0), .out_data(data0),
    .out_src(src0), .out_valid(val0), .out_ready(out_ready));

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N), .PRIO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy1), .out_data(data1),
    .out_src(src1), .out_valid(val1), .out_ready(out_ready));

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
    chdat[i] = v;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(i, 32'hC0DE_0000 | W'(i));
    tick(); tick();
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", val0); end
    checks++; if (data0 !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data0); end
    checks++; if (src0 !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", src0); end
    checks++; if (rdy0 !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", rdy0); end
    in_valid = 4'b0000;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_ch(2, 32'hDEAD_BEEF);
    in_valid = 4'b0100; out_ready = 1'b1; #1;
    checks++; if (rdy0 !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", rdy0); end
    tick();
    checks++; if (val0 !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", val0); end
    checks++; if (data0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", data0); end
    checks++; if (src0 !== 2'd2) begin errors++; $display("FAIL single_src got=%0d exp=2", src0); end
    // Pointer now 3: with every channel requesting, ch3 must be offered.
    in_valid = 4'b1111; out_ready = 1'b0; #1;
    checks++; if (rdy0 !== 4'b0000) begin errors++; $display("FAIL single_stall_ready got=%b exp=0000", rdy0); end
    out_ready = 1'b1; #1;
    checks++; if (rdy0 !== 4'b1000) begin errors++; $display("FAIL single_ptr3_ready got=%b exp=1000", rdy0); end
    // Drain without refill.
    in_valid = 4'b0000;
    tick();
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", val0); end
    checks++; if (data0 !== 32'hDEAD_BEEF || src0 !== 2'd2) begin errors++; $display("FAIL drain_hold got=%h/%0d exp=deadbeef/2", data0, src0); end
    // No requests: nothing granted.
    #1;
    checks++; if (rdy0 !== 4'b0000) begin errors++; $display("FAIL idle_ready got=%b exp=0000", rdy0); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_src [5];
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    // Load ch3 so the pointer wraps to 0.
    in_valid = 4'b1000;
    tick();
    checks++; if (src0 !== 2'd3 || val0 !== 1'b1) begin errors++; $display("FAIL rot_prime got=%0d/%b exp=3/1", src0, val0); end
    in_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (val0 !== 1'b1 || src0 !== exp_src[c] || data0 !== chdat[exp_src[c]]) begin
        errors++;
        $display("FAIL rot_step%0d got=%b/%0d/%h exp=1/%0d/%h", c, val0, src0, data0, exp_src[c], chdat[exp_src[c]]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_ch(1, 32'h0000_0011);
    in_valid = 4'b0010;
    tick();
    checks++; if (src0 !== 2'd1 || data0 !== 32'h0000_0011) begin errors++; $display("FAIL bp_load got=%0d/%h exp=1/00000011", src0, data0); end
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rdy0 !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got=%b exp=0000", c, rdy0); end
      tick();
      checks++;
      if (val0 !== 1'b1 || src0 !== 2'd1 || data0 !== 32'h0000_0011) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%0d/%h exp=1/1/00000011", c, val0, src0, data0);
      end
    end
    out_ready = 1'b1; #1;
    checks++; if (rdy0 !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b exp=0100", rdy0); end
    tick();
    checks++; if (src0 !== 2'd2 || val0 !== 1'b1) begin errors++; $display("FAIL bp_release_src got=%0d/%b exp=2/1", src0, val0); end
  endtask

  task automatic test_flush();
    // dut0 holds ch2, pointer at 3.
    out_ready = 1'b0; flush = 1'b1; in_valid = 4'b0001; #1;
    checks++; if (rdy0 !== 4'b0000) begin errors++; $display("FAIL flush_ready got=%b exp=0000", rdy0); end
    tick();
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", val0); end
    checks++; if (src0 !== 2'd2) begin errors++; $display("FAIL flush_src_hold got=%0d exp=2", src0); end
    flush = 1'b0; #1;
    checks++; if (rdy0 !== 4'b0001) begin errors++; $display("FAIL postflush_ready got=%b exp=0001", rdy0); end
    tick();
    checks++; if (val0 !== 1'b1 || src0 !== 2'd0 || data0 !== chdat[0]) begin errors++; $display("FAIL postflush_load got=%b/%0d/%h exp=1/0/%h", val0, src0, data0, chdat[0]); end
  endtask

  task automatic test_fixed_prio();
    // dut0 pointer is 1 here, so round-robin alternates 1,3,1.
    logic [1:0] rr_src [3];
    rr_src = '{2'd1, 2'd3, 2'd1};
    out_ready = 1'b1; in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rdy1 !== 4'b0010) begin errors++; $display("FAIL prio_ready%0d got=%b exp=0010", c, rdy1); end
      tick();
      checks++; if (src1 !== 2'd1 || val1 !== 1'b1) begin errors++; $display("FAIL prio_src%0d got=%0d/%b exp=1/1", c, src1, val1); end
      checks++; if (src0 !== rr_src[c]) begin errors++; $display("FAIL rr_alt%0d got=%0d exp=%0d", c, src0, rr_src[c]); end
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0; #1;
    checks++; if (val0 !== 1'b0 || data0 !== 32'h0 || src0 !== 2'd0) begin errors++; $display("FAIL areset got=%b/%h/%0d exp=0/0/0", val0, data0, src0); end
    checks++; if (rdy0 !== 4'b0000) begin errors++; $display("FAIL areset_ready got=%b exp=0000", rdy0); end
    #1;
    rst = 1'b1;
    in_valid = 4'b1000; #1;
    checks++; if (rdy0 !== 4'b1000) begin errors++; $display("FAIL arel_ready got=%b exp=1000", rdy0); end
    tick();
    checks++; if (src0 !== 2'd3 || val0 !== 1'b1) begin errors++; $display("FAIL arel_src got=%0d/%b exp=3/1", src0, val0); end
    in_valid = 4'b1111; #1;
    checks++; if (rdy0 !== 4'b0001) begin errors++; $display("FAIL arel_wrap_ready got=%b exp=0001", rdy0); end
    tick();
    checks++; if (src0 !== 2'd0) begin errors++; $display("FAIL arel_wrap_src got=%0d exp=0", src0); end
    in_valid = 4'b0000;
  endtask

  initial begin
    in_data = '0;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_flush();
    test_fixed_prio();
    test_async_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
